// File: rtl/lcd_bus_scheduler.sv
// Purpose : shares an HD44780-style character-LCD write bus between two clients and
//           runs the power-up wait plus the fixed init command list after reset.
// Latency : acceptance in cycle t -> bus valid t+1, E high from t+1+SETUP_CYC for
//           E_PW_CYC cycles, IDLE again after the hold and the post-command wait.
// Backpressure: reqN_ready is combinational, high only in IDLE after init, for one winner.
// Ports   : clk, rst (sync, active high); req0_*/req1_* valid/rs/data/ready client
//           handshakes; RS, RW (tied 0), E, data drive the LCD pins; init_done is
//           sticky until reset; busy is high whenever the sequencer is not idle.
// Config  : define LCD_SCHED_RR_EN for round-robin arbitration; without it client 0
//           has fixed priority and the round-robin pointer does not exist.
module lcd_bus_scheduler #(
    parameter int SETUP_CYC     = 4,
    parameter int E_PW_CYC      = 25,
    parameter int CMD_WAIT_CYC  = 2500,
    parameter int LONG_WAIT_CYC = 100000,
    parameter int PWRUP_CYC     = 2500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic       req0_rs,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic       req1_rs,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       RS,
    output logic       RW,
    output logic       E,
    output logic [7:0] data,
    output logic       init_done,
    output logic       busy
);

    localparam int MAX_A   = (SETUP_CYC > E_PW_CYC) ? SETUP_CYC : E_PW_CYC;
    localparam int MAX_B   = (CMD_WAIT_CYC > LONG_WAIT_CYC) ? CMD_WAIT_CYC : LONG_WAIT_CYC;
    localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_CYC = (MAX_C > PWRUP_CYC) ? MAX_C : PWRUP_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] EPW_LD   = CNT_W'(E_PW_CYC - 1);
    localparam logic [CNT_W-1:0] CMD_LD   = CNT_W'(CMD_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(LONG_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] PWRUP_LD = CNT_W'(PWRUP_CYC - 1);

    localparam logic [2:0] LAST_IDX = 3'd6;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_INIT_LOAD,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_WAIT,
        ST_IDLE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic             rs_q, rs_d;
    logic [7:0]       data_q, data_d;
    logic             e_q, e_d;
    logic             done_q, done_d;
    logic             grant0, grant1;
    logic             cnt_zero;
    logic             long_cmd;

    // Fixed 8-bit interface init list: function set x3, 8-bit/2-line, display on,
    // clear, entry mode.
    function automatic logic [7:0] init_cmd(input logic [2:0] i);
        case (i)
            3'd0, 3'd1, 3'd2: init_cmd = 8'h30;
            3'd3:             init_cmd = 8'h38;
            3'd4:             init_cmd = 8'h0C;
            3'd5:             init_cmd = 8'h01;
            3'd6:             init_cmd = 8'h06;
            default:          init_cmd = 8'h00;
        endcase
    endfunction

`ifdef LCD_SCHED_RR_EN
    // ptr_q == 0 favours client 0 on a tie, 1 favours client 1.
    logic ptr_q, ptr_d;
    assign grant0 = req0_valid && (!req1_valid || !ptr_q);
    assign grant1 = req1_valid && (!req0_valid ||  ptr_q);
`else
    assign grant0 = req0_valid;
    assign grant1 = req1_valid && !req0_valid;
`endif

    assign cnt_zero = (cnt_q == '0);
    // Clear (01) and return-home (02/03) need the long execution wait.
    assign long_cmd = !rs_q && (data_q[7:2] == 6'b0);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        rs_d       = rs_q;
        data_d     = data_q;
        e_d        = e_q;
        done_d     = done_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
`ifdef LCD_SCHED_RR_EN
        ptr_d      = ptr_q;
`endif
        case (state_q)
            ST_PWRUP: begin
                if (cnt_zero) begin
                    // The init entry is put on the bus as INIT_LOAD is entered, so
                    // INIT_LOAD itself is the first setup cycle of that transfer.
                    state_d = ST_INIT_LOAD;
                    rs_d    = 1'b0;
                    data_d  = init_cmd(idx_q);
                    cnt_d   = SETUP_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_INIT_LOAD: begin
                // Counting continues from the value loaded on entry, so the whole
                // setup phase still spans SETUP_CYC cycles.
                if (cnt_zero) begin
                    state_d = ST_PULSE;
                    e_d     = 1'b1;
                    cnt_d   = EPW_LD;
                end else begin
                    state_d = ST_SETUP;
                    cnt_d   = cnt_q - 1'b1;
                end
            end
            ST_SETUP: begin
                if (cnt_zero) begin
                    state_d = ST_PULSE;
                    e_d     = 1'b1;
                    cnt_d   = EPW_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_PULSE: begin
                if (cnt_zero) begin
                    state_d = ST_HOLD;
                    e_d     = 1'b0;
                    cnt_d   = SETUP_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_zero) begin
                    state_d = ST_WAIT;
                    cnt_d   = long_cmd ? LONG_LD : CMD_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_WAIT: begin
                if (cnt_zero) begin
                    // Before init_done every transfer is an init entry.
                    if (!done_q && (idx_q != LAST_IDX)) begin
                        state_d = ST_INIT_LOAD;
                        idx_d   = idx_q + 3'd1;
                        rs_d    = 1'b0;
                        data_d  = init_cmd(idx_q + 3'd1);
                        cnt_d   = SETUP_LD;
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_IDLE: begin
                if (done_q && grant0) begin
                    req0_ready = 1'b1;
                    state_d    = ST_SETUP;
                    rs_d       = req0_rs;
                    data_d     = req0_data;
                    cnt_d      = SETUP_LD;
`ifdef LCD_SCHED_RR_EN
                    ptr_d      = 1'b1;
`endif
                end else if (done_q && grant1) begin
                    req1_ready = 1'b1;
                    state_d    = ST_SETUP;
                    rs_d       = req1_rs;
                    data_d     = req1_data;
                    cnt_d      = SETUP_LD;
`ifdef LCD_SCHED_RR_EN
                    ptr_d      = 1'b0;
`endif
                end
            end
            default: begin
                state_d = ST_PWRUP;
                cnt_d   = PWRUP_LD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_PWRUP;
            cnt_q   <= PWRUP_LD;
            idx_q   <= 3'd0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            e_q     <= 1'b0;
            done_q  <= 1'b0;
`ifdef LCD_SCHED_RR_EN
            ptr_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            e_q     <= e_d;
            done_q  <= done_d;
`ifdef LCD_SCHED_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign RS        = rs_q;
    assign RW        = 1'b0;
    assign E         = e_q;
    assign data      = data_q;
    assign init_done = done_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: doc/lcd_bus_scheduler.md
# lcd_bus_scheduler

Shares the character-LCD parallel bus (RS, RW, E, DB7-0) between two client requesters and sequences every transfer with HD44780-style timing. After reset it runs the power-up wait and fixed initialisation command list by itself. It then grants one client transfer at a time and applies the correct post-command wait: long for clear/home, short otherwise. It sits between application logic (text writers, status updaters) and the GPIO pins driving the LCD module.

## Interface
- `SETUP_CYC`, default 4: cycles RS/data are stable before E rises, and held after E falls.
- `E_PW_CYC`, default 25: E high width in cycles (500 ns at 50 MHz).
- `CMD_WAIT_CYC`, default 2500: post-transfer wait for normal commands and data (50 µs).
- `LONG_WAIT_CYC`, default 100000: post-transfer wait for clear/return-home (2 ms).
- `PWRUP_CYC`, default 2500000: wait after reset before the first init command (50 ms).
- `clk` in, 1: 50 MHz system clock.
- `rst` in, 1: synchronous, active-high reset.
- `req0_valid` in, 1: client 0 has a transfer.
- `req0_rs` in, 1: client 0 register select (0 = command, 1 = data).
- `req0_data` in, 8: client 0 byte.
- `req0_ready` out, 1: client 0 transfer accepted this cycle when `req0_valid` is also high.
- `req1_valid`, `req1_rs`, `req1_data`, `req1_ready`: same as client 0, for client 1.
- `RS` out, 1: LCD register select.
- `RW` out, 1: LCD read/write. Held 0; writes only.
- `E` out, 1: LCD enable. The LCD latches on the falling edge.
- `data` out, 8: LCD data bus.
- `init_done` out, 1: init list complete. Sticky until reset.
- `busy` out, 1: high whenever the state is not IDLE.

## Operation
- States: PWRUP, INIT_LOAD, SETUP, PULSE, HOLD, WAIT, IDLE.
- Reset values: RS=0, RW=0, E=0, data=8'h00, req*_ready=0, init_done=0, busy=1, init index=0, round-robin pointer = client 0, state=PWRUP.
- PWRUP:
  - Count PWRUP_CYC cycles, then go to INIT_LOAD.
- INIT_LOAD:
  - Load init entry `idx` with RS=0: 8'h30, 8'h30, 8'h30, 8'h38, 8'h0C, 8'h01, 8'h06.
  - Go to SETUP.
- SETUP:
  - E=0, RS and data driven.
  - After SETUP_CYC cycles go to PULSE.
- PULSE:
  - E=1 for E_PW_CYC cycles, then go to HOLD.
- HOLD:
  - E=0, RS/data unchanged, for SETUP_CYC cycles.
  - Then go to WAIT.
- WAIT:
  - Select the wait length:
    - LONG_WAIT_CYC if RS=0 and data[7:2]==6'b0, i.e. 8'h01, 8'h02 or 8'h03.
    - CMD_WAIT_CYC otherwise.
  - When the wait expires, if the last transfer was an init entry:
    - If idx<6: idx+1, go to INIT_LOAD.
    - If idx==6: set init_done, go to IDLE.
  - When the wait expires after a client transfer: go to IDLE.
- IDLE:
  - Arbitrate among the valid requesters.
  - Assert exactly one `reqN_ready` combinationally, for the winner.
  - On valid&&ready, latch reqN_rs/reqN_data into RS/data, go to SETUP, and update the pointer to favour the other client.
  - With no request, stay in IDLE with E=0 and the bus holding its last value.
- Clients may change `reqN_data`/`reqN_rs` freely while not accepted. A valid that is dropped before acceptance is simply not serviced.
- All cycle counters share one down-counter:
  - Width is $clog2 of the largest parameter, plus 1.
  - Loaded with N-1 on state entry; exit occurs when it reaches 0.
  - No wrap-around.

## Timing
- Acceptance in cycle t:
  - RS/data valid from t+1.
  - E rises at t+1+SETUP_CYC and falls at t+1+SETUP_CYC+E_PW_CYC.
  - IDLE is re-entered at t+1+2·SETUP_CYC+E_PW_CYC+wait. No ready is asserted before then.
- Back-to-back: the earliest next acceptance is the first IDLE cycle. ready is never high outside IDLE or before init_done.
- Both valid in the same IDLE cycle: the pointer's client wins. The loser stays valid and wins next IDLE.
- Reset asserted mid-transfer (any state): all outputs take their reset values on the next edge, E included. Any in-flight transfer is dropped, and power-up restarts.
- E is a registered output with no combinational path from inputs.

## Configuration
- `LCD_SCHED_RR_EN`:
  - Defined: round-robin arbitration as above.
  - Undefined: fixed priority. Client 0 always wins a tie, the pointer logic is removed, and client 1 is served only when req0_valid=0 in IDLE.

## Test plan
- Bench parameters for all scenarios: SETUP_CYC=2, E_PW_CYC=3, CMD_WAIT_CYC=5, LONG_WAIT_CYC=20, PWRUP_CYC=10.
- Release reset, no requests:
  - Seven E pulses with data 30,30,30,38,0C,01,06 and RS=0.
  - The gap after the 8'h01 pulse reflects LONG wait.
  - init_done rises exactly 10 + 7·(2·2+3) + 6·5 + 20 cycles after the first cycle with rst low.
- After init, req0 sends RS=1, data=8'h50 ('P'):
  - req0_ready pulses for 1 cycle.
  - E is high 3 cycles, starting 3 cycles after acceptance, with data=50 and RS=1 throughout.
  - busy drops 2+3+2+5+1 cycles after acceptance.
- Both clients valid continuously in IDLE (req0=41, req1=42, RS=1), with RR enabled:
  - Bus sequence is 41,42,41,42.
  - With LCD_SCHED_RR_EN undefined: 41,41,41,41.
- req1 sends command 8'h02: post-transfer wait is 20 cycles; command 8'h0C waits 5.
- rst asserted during PULSE: E=0, data=00, init_done=0 on the next edge, then the full init sequence reruns.
- req0_valid asserted before init_done: req0_ready stays 0 until after init_done, then the transfer is accepted in the first IDLE cycle.
